keypad_conditioner: RTL

Input conditioning stage directly upstream of the password checker FSM. It takes the raw, asynchronous, bouncing keypad lines (10 digit keys plus the start and confirm keys) and synchronises and debounces them. It emits a clean one-hot digit code with a one-cycle valid strobe, and one-cycle start/rmx pulses. Simultaneous multi-key presses are rejected so the checker only ever sees a legal one-hot code or zero.

---
 rtl/keypad_conditioner_pkg.sv | 28 ++
 rtl/keypad_conditioner_if.sv | 27 ++
 rtl/keypad_conditioner_key_filter.sv | 49 ++++
 rtl/keypad_conditioner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/keypad_conditioner_pkg.sv
// Shared definitions for the keypad conditioner and the password checker.
// Holds the key width, the debounce defaults, the digit FSM encoding and
// the registered output bundle of the digit path.
package keypad_conditioner_pkg;

  localparam int KEY_W               = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } dig_state_e;

  typedef struct packed {
    logic [KEY_W-1:0] button;
    logic             btn_valid;
    logic             multi_err;
  } dig_out_t;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/keypad_conditioner_if.sv
// Keypad conditioner signal bundle.
//   raw_btn/raw_start/raw_rmx : raw asynchronous key lines (keypad side)
//   button/btn_valid/start/rmx/multi_err : conditioned outputs
// master = keypad/consumer side, slave = conditioner side.
interface keypad_conditioner_if;
  import keypad_conditioner_pkg::*;

  logic [KEY_W-1:0] raw_btn;
  logic             raw_start;
  logic             raw_rmx;
  logic [KEY_W-1:0] button;
  logic             btn_valid;
  logic             start;
  logic             rmx;
  logic             multi_err;

  modport master (
    output raw_btn, raw_start, raw_rmx,
    input  button, btn_valid, start, rmx, multi_err
  );

  modport slave (
    input  raw_btn, raw_start, raw_rmx,
    output button, btn_valid, start, rmx, multi_err
  );

endinterface

// File: rtl/keypad_conditioner_key_filter.sv
// Single-key conditioner: 2-flop synchroniser, debounce counter and
// rising-edge pulse of the debounced level.
//   clk, n_rst : clock, async active-low reset
//   raw        : raw asynchronous key line
//   pulse      : one-cycle pulse on each debounced press
module keypad_conditioner_key_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_pipe;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any agreeing sample restarts the run. It tops out at
  // CNT_MAX, where the level flips and the count restarts, so it never wraps.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_pipe <= '0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      pulse_q   <= 1'b0;
      if (sync_pipe[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_pipe[1];
        cnt_q   <= '0;
        pulse_q <= sync_pipe[1];   // rising edge only; release is silent
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad input conditioner: synchronises and debounces the 10 digit keys
// and the start/confirm keys. Digits come out as a held one-hot code with a
// one-cycle valid strobe; multi-key presses are rejected with multi_err.
//   clk, n_rst : clock, async active-low reset
//   kp         : slave side of keypad_conditioner_if (raw in, clean out)
module keypad_conditioner
  import keypad_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // 2 .. 2**CNT_W-1
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  n_rst,
  keypad_conditioner_if.slave   kp
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------- start / rmx filters ----------------
  logic [1:0] raw_ev;
  logic [1:0] ev_pulse;

  assign raw_ev = {kp.raw_rmx, kp.raw_start};

  for (genvar i = 0; i < 2; i++) begin : g_filt
    keypad_conditioner_key_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_filter (
      .clk  (clk),
      .n_rst(n_rst),
      .raw  (raw_ev[i]),
      .pulse(ev_pulse[i])
    );
  end

  assign kp.start = ev_pulse[0];
  assign kp.rmx   = ev_pulse[1];

  // ---------------- digit path ----------------
  logic [1:0][KEY_W-1:0] btn_sync;
  logic [KEY_W-1:0]      sync_btn;

  dig_state_e       state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;
  dig_out_t         out_q, out_d;

  assign sync_btn = btn_sync[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_sync <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
      out_q    <= '0;
    end else begin
      btn_sync <= {btn_sync[0], kp.raw_btn};
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cand_d           = cand_q;
    cnt_d            = cnt_q;
    reject_d         = reject_q;
    out_d            = out_q;
    out_d.btn_valid  = 1'b0;
    out_d.multi_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_btn != '0) begin
          cand_d  = sync_btn;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_btn == '0) begin
          state_d = IDLE;
        end else if (sync_btn != cand_q) begin
          // A different vector restarts the stability run.
          cand_d = sync_btn;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          if (is_onehot(cand_q)) begin
            out_d.button    = cand_q;
            out_d.btn_valid = 1'b1;
            reject_d        = 1'b0;
          end else begin
            out_d.button    = '0;
            out_d.multi_err = 1'b1;
            reject_d        = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // Vector changes while held are ignored; only all-released matters.
        if (sync_btn == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sync_btn != '0) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          out_d.button = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kp.button    = out_q.button;
  assign kp.btn_valid = out_q.btn_valid;
  assign kp.multi_err = out_q.multi_err;

endmodule
